// File: rtl/simplez_bus_responder_pkg.sv
// Shared definitions for the SIMPLEZ bus responder: I/O address map,
// opcode constants and transmitter state encoding.
package simplez_defs;

    localparam logic [8:0] ADDR_LED    = 9'd508;
    localparam logic [8:0] ADDR_STATUS = 9'd509;
    localparam logic [8:0] ADDR_TXDATA = 9'd510;
    localparam logic [8:0] ADDR_RSVD   = 9'd511;

    // RAM occupies every address below the first I/O register
    localparam int RAM_WORDS = 508;

    localparam logic [2:0] OP_HALT = 3'o7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [11:0] instr_word(input logic [2:0] op);
        return {op, 9'd0};
    endfunction

endpackage

// File: rtl/simplez_bus_responder_uart_tx.sv
// 8N1 serial transmitter; every bit lasts CLK_HZ/BAUD clocks, state moves on falling edges.
module uart_tx
    import simplez_defs::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       ready
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] baud_reg, baud_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic             busy_reg;
    logic             last_tick;

    assign last_tick = (baud_reg == CNT_LAST);
    assign tx        = tx_reg;
    assign busy      = busy_reg;
    // A new byte may be taken while idle or on the closing clock of the stop bit
    assign ready     = (state_reg == TX_IDLE) || ((state_reg == TX_STOP) && last_tick);

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= TX_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            busy_reg  <= (state_next != TX_IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = 1'b1;
        case (state_reg)
            TX_IDLE: begin
                if (start) begin
                    state_next = TX_START;
                    baud_next  = '0;
                    shift_next = data;
                end
            end
            TX_START: begin
                if (last_tick) begin
                    state_next = TX_DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (last_tick) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = TX_STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (last_tick) begin
                    state_next = TX_IDLE;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: state_next = TX_IDLE;
        endcase
        // Line level follows the state being entered so tx changes with the state
        case (state_next)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = shift_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

endmodule

// File: rtl/simplez_bus_responder.sv
// SIMPLEZ memory-bus target: 508-word RAM plus LED, status and serial TX registers.
// All state changes on the falling clock edge, in step with the CPU.
module simplez_bus_responder
    import simplez_defs::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int BAUD      = 115_200,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [8:0]  addr,
    input  logic        lec,
    input  logic        esc,
    input  logic [11:0] data_in,
    output logic [11:0] data_out,
    output logic [3:0]  dataled,
    output logic        tx,
    output logic        tx_busy
);

    typedef logic [11:0] mem_t [RAM_WORDS];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < RAM_WORDS; i++) begin
            m[i] = '0;
        end
        m[0] = instr_word(OP_HALT);
        return m;
    endfunction

    mem_t mem = mem_init();

    logic [11:0] data_out_reg;
    logic [3:0]  led_reg;
    logic        overrun_reg;
    logic        tx_start_reg;
    logic [7:0]  tx_data_reg;
    logic [11:0] io_rdata;
    logic        is_ram, rd_en, tx_write, tx_accept, tx_ready;

    assign is_ram    = (addr < ADDR_LED);
    assign rd_en     = lec & ~esc;
    assign tx_write  = esc && (addr == ADDR_TXDATA);
    // The pending start is still invisible to tx_busy, so it must also block a second byte
    assign tx_accept = tx_write & tx_ready & ~tx_start_reg;

    assign data_out = data_out_reg;
    assign dataled  = led_reg;

    always_ff @(negedge clk) begin
        if (esc && is_ram) begin
            mem[addr] <= data_in;
        end
    end

    always_comb begin
        io_rdata = '0;
        case (addr)
            ADDR_LED:    io_rdata = {8'd0, led_reg};
            ADDR_STATUS: io_rdata = {10'd0, overrun_reg, ~tx_busy};
            default:     io_rdata = '0;
        endcase
    end

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out_reg <= '0;
            led_reg      <= '0;
            overrun_reg  <= 1'b0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            tx_start_reg <= tx_accept;
            if (tx_accept) begin
                tx_data_reg <= data_in[7:0];
            end
            if (esc && (addr == ADDR_LED)) begin
                led_reg <= data_in[3:0];
            end
            if (tx_write && !tx_accept) begin
                overrun_reg <= 1'b1;
            end else if (rd_en && (addr == ADDR_STATUS)) begin
                overrun_reg <= 1'b0;
            end
            if (rd_en) begin
                data_out_reg <= is_ram ? mem[addr] : io_rdata;
            end
        end
    end

    uart_tx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart_tx (
        .clk   (clk),
        .rstn  (rstn),
        .start (tx_start_reg),
        .data  (tx_data_reg),
        .tx    (tx),
        .busy  (tx_busy),
        .ready (tx_ready)
    );

endmodule
